// File: rtl/sm_matrix_n_pkg.sv
`default_nettype none
// ============================================================================
// sm_matrix_n_pkg : shared FSM encoding and default memory map for the matrix
// Revision 1.0
// ============================================================================
package sm_matrix_n_pkg;

  typedef enum logic [1:0] {
    SM_MX_IDLE = 2'd0,
    SM_MX_BUSY = 2'd1,
    SM_MX_ERR  = 2'd2
  } sm_mx_state_e;

  // Scratchpad / AHB windows of the existing two-slave memory map
  localparam logic [31:0] SM_MX_SPM_BASE = 32'h0000_0000;
  localparam logic [31:0] SM_MX_SPM_MASK = 32'hE000_0000;
  localparam logic [31:0] SM_MX_AHB_BASE = 32'h2000_0000;
  localparam logic [31:0] SM_MX_AHB_MASK = 32'hE000_0000;

  function automatic int sm_mx_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_matrix_n_decoder.sv
`default_nettype none
// ============================================================================
// sm_matrix_n_decoder : address -> one-hot slave select, lowest hit index wins
// Revision 1.0
// ============================================================================
module sm_matrix_n_decoder
  import sm_matrix_n_pkg::*;
#(
  parameter int                      N_SLAVES  = 4,
  parameter logic [N_SLAVES*32-1:0]  ADDR_BASE = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*32-1:0]  ADDR_MASK = {N_SLAVES{32'h0}},
  parameter int                      IDX_W     = sm_mx_idx_w(N_SLAVES)
) (
  input  logic [31:0]         addr_i,
  output logic [N_SLAVES-1:0] sel_oh_o,
  output logic [IDX_W-1:0]    sel_idx_o,
  output logic                hit_o
);

  always_comb begin
    sel_oh_o  = '0;
    sel_idx_o = '0;
    hit_o     = 1'b0;
    // Scan downwards so the lowest matching index is the last one written
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (((addr_i ^ ADDR_BASE[i*32 +: 32]) & ADDR_MASK[i*32 +: 32]) == 32'h0) begin
        sel_oh_o    = '0;
        sel_oh_o[i] = 1'b1;
        sel_idx_o   = IDX_W'(i);
        hit_o       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sm_matrix_n.sv
`default_nettype none
// ============================================================================
// sm_matrix_n : single-master to N_SLAVES interconnect, one outstanding access
// Revision 1.0
// ============================================================================
module sm_matrix_n
  import sm_matrix_n_pkg::*;
#(
  parameter int                      N_SLAVES  = 4,
  parameter logic [N_SLAVES*32-1:0]  ADDR_BASE = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*32-1:0]  ADDR_MASK = {N_SLAVES{32'h0}},
  parameter int                      TIMEOUT   = 255,
  parameter int                      TO_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            a,
  input  logic                   we,
  input  logic [31:0]            wd,
  input  logic                   valid,
  output logic                   ready,
  output logic [31:0]            rd,
  output logic                   err,
  output logic [N_SLAVES-1:0]    s_valid,
  output logic [31:0]            s_a,
  output logic                   s_we,
  output logic [31:0]            s_wd,
  input  logic [N_SLAVES-1:0]    s_ready,
  input  logic [N_SLAVES*32-1:0] s_rd
);

  localparam int IDX_W = sm_mx_idx_w(N_SLAVES);

  sm_mx_state_e      state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;

  logic [N_SLAVES-1:0] dec_oh;
  logic [IDX_W-1:0]    dec_idx;
  logic                dec_hit;

  sm_matrix_n_decoder #(
    .N_SLAVES  (N_SLAVES),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_MASK (ADDR_MASK),
    .IDX_W     (IDX_W)
  ) u_dec (
    .addr_i    (a),
    .sel_oh_o  (dec_oh),
    .sel_idx_o (dec_idx),
    .hit_o     (dec_hit)
  );

  assign s_a  = a;
  assign s_we = we;
  assign s_wd = wd;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    s_valid = '0;
    ready   = 1'b0;
    err     = 1'b0;
    rd      = 32'h0;
    // Outputs are forced quiet while reset is held, even with valid high
    if (!rst) begin
      case (state_q)
        SM_MX_IDLE: begin
          if (valid) begin
            if (dec_hit) begin
              s_valid = dec_oh;
              sel_d   = dec_idx;
              cnt_d   = '0;
              state_d = SM_MX_BUSY;
            end else begin
              state_d = SM_MX_ERR;
            end
          end
        end
        SM_MX_BUSY: begin
          if (s_ready[sel_q]) begin
            ready   = 1'b1;
            rd      = s_rd[{sel_q, 5'd0} +: 32];
            state_d = SM_MX_IDLE;
          end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
            ready   = 1'b1;
            err     = 1'b1;
            state_d = SM_MX_IDLE;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        SM_MX_ERR: begin
          ready   = 1'b1;
          err     = 1'b1;
          state_d = SM_MX_IDLE;
        end
        default: state_d = SM_MX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SM_MX_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sm_matrix_n.sv
`default_nettype none
// ============================================================================
// tb_sm_matrix_n : directed checks on a scratchpad/AHB map and an overlap map
// Revision 1.0
// ============================================================================
module tb_sm_matrix_n;
  import sm_matrix_n_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Instance A: scratchpad/AHB map, default timeout
  logic [31:0] aA = '0, wdA = '0;
  logic        weA = 1'b0, validA = 1'b0;
  logic        readyA, errA, s_weA;
  logic [31:0] rdA, s_aA, s_wdA;
  logic [1:0]  s_validA;
  logic [1:0]  s_readyA = '0;
  logic [63:0] s_rdA = '0;

  sm_matrix_n #(
    .N_SLAVES  (2),
    .ADDR_BASE ({SM_MX_AHB_BASE, SM_MX_SPM_BASE}),
    .ADDR_MASK ({SM_MX_AHB_MASK, SM_MX_SPM_MASK}),
    .TIMEOUT   (255),
    .TO_W      (8)
  ) dut_a (
    .clk(clk), .rst(rst), .a(aA), .we(weA), .wd(wdA), .valid(validA),
    .ready(readyA), .rd(rdA), .err(errA), .s_valid(s_validA), .s_a(s_aA),
    .s_we(s_weA), .s_wd(s_wdA), .s_ready(s_readyA), .s_rd(s_rdA)
  );

  // Instance B: overlapping map, short timeout
  logic [31:0] aB = '0, wdB = '0;
  logic        weB = 1'b0, validB = 1'b0;
  logic        readyB, errB, s_weB;
  logic [31:0] rdB, s_aB, s_wdB;
  logic [1:0]  s_validB;
  logic [1:0]  s_readyB = '0;
  logic [63:0] s_rdB = '0;

  sm_matrix_n #(
    .N_SLAVES  (2),
    .ADDR_BASE ({32'h0000_0000, 32'h0000_0000}),
    .ADDR_MASK ({32'h8000_0000, 32'hE000_0000}),
    .TIMEOUT   (4),
    .TO_W      (8)
  ) dut_b (
    .clk(clk), .rst(rst), .a(aB), .we(weB), .wd(wdB), .valid(validB),
    .ready(readyB), .rd(rdB), .err(errB), .s_valid(s_validB), .s_a(s_aB),
    .s_we(s_weB), .s_wd(s_wdB), .s_ready(s_readyB), .s_rd(s_rdB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, with valid high to show s_valid stays quiet
    aA = 32'h10; validA = 1'b1;
    #3;
    chk("rst_ready", 32'(readyA), 32'h0);
    chk("rst_err", 32'(errA), 32'h0);
    chk("rst_svalid", 32'(s_validA), 32'h0);
    chk("rst_rd", rdA, 32'h0);
    validA = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // 1: read slave0, completes next cycle
    tick(); aA = 32'h0000_0010; weA = 1'b0; validA = 1'b1; #3;
    chk("t1_svalid", 32'(s_validA), 32'h1);
    chk("t1_sa", s_aA, 32'h0000_0010);
    chk("t1_ready0", 32'(readyA), 32'h0);
    tick(); validA = 1'b0; s_readyA = 2'b01; s_rdA[31:0] = 32'h1234_5678; #3;
    chk("t1_svalid_busy", 32'(s_validA), 32'h0);
    chk("t1_ready", 32'(readyA), 32'h1);
    chk("t1_rd", rdA, 32'h1234_5678);
    chk("t1_err", 32'(errA), 32'h0);
    tick(); s_readyA = 2'b00; #3;
    chk("t1_ready_drop", 32'(readyA), 32'h0);

    // 2: write slave1 with a 5-cycle stall
    aA = 32'h2000_0004; weA = 1'b1; wdA = 32'hCAFE_F00D; validA = 1'b1; #1;
    chk("t2_svalid", 32'(s_validA), 32'h2);
    chk("t2_swd", s_wdA, 32'hCAFE_F00D);
    chk("t2_swe", 32'(s_weA), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      tick(); validA = 1'b0; #3;
      chk("t2_stall", 32'(readyA), 32'h0);
    end
    tick(); s_readyA = 2'b10; s_rdA[63:32] = 32'hDEAD_BEEF; #3;
    chk("t2_ready", 32'(readyA), 32'h1);
    chk("t2_err", 32'(errA), 32'h0);
    chk("t2_rd", rdA, 32'hDEAD_BEEF);

    // 3: unmapped access completes with an error
    tick(); s_readyA = 2'b00; weA = 1'b0; aA = 32'hF000_0000; validA = 1'b1; #3;
    chk("t3_svalid", 32'(s_validA), 32'h0);
    chk("t3_ready0", 32'(readyA), 32'h0);
    tick(); validA = 1'b0; #3;
    chk("t3_ready", 32'(readyA), 32'h1);
    chk("t3_err", 32'(errA), 32'h1);
    chk("t3_rd", rdA, 32'h0);
    tick(); #3;
    chk("t3_ready_drop", 32'(readyA), 32'h0);

    // 5b: back-to-back slave0 then slave1
    aA = 32'h0000_0100; validA = 1'b1; #1;
    chk("bb_svalid0", 32'(s_validA), 32'h1);
    tick(); aA = 32'h2000_0100; s_readyA = 2'b01; s_rdA[31:0] = 32'hA5A5_0001; #3;
    chk("bb_ready0", 32'(readyA), 32'h1);
    chk("bb_rd0", rdA, 32'hA5A5_0001);
    chk("bb_svalid_busy", 32'(s_validA), 32'h0);
    tick(); s_readyA = 2'b00; #3;
    chk("bb_svalid1", 32'(s_validA), 32'h2);
    tick(); validA = 1'b0; s_readyA = 2'b10; s_rdA[63:32] = 32'h5A5A_0002; #3;
    chk("bb_ready1", 32'(readyA), 32'h1);
    chk("bb_rd1", rdA, 32'h5A5A_0002);
    tick(); s_readyA = 2'b00;

    // 5: overlap, lowest index wins; slave1-only address goes to slave1
    aB = 32'h0; validB = 1'b1; #1;
    chk("ov_svalid0", 32'(s_validB), 32'h1);
    tick(); validB = 1'b0; s_readyB = 2'b01; s_rdB[31:0] = 32'h1111_0000; #3;
    chk("ov_rd0", rdB, 32'h1111_0000);
    chk("ov_ready0", 32'(readyB), 32'h1);
    tick(); s_readyB = 2'b00; aB = 32'h4000_0000; validB = 1'b1; #3;
    chk("ov_svalid1", 32'(s_validB), 32'h2);
    tick(); validB = 1'b0; s_readyB = 2'b10; s_rdB[63:32] = 32'h2222_0000; #3;
    chk("ov_rd1", rdB, 32'h2222_0000);
    tick(); s_readyB = 2'b00;

    // 4: timeout 4 cycles after the request, late s_ready ignored
    aB = 32'h0; validB = 1'b1; #1;
    chk("to_svalid", 32'(s_validB), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      tick(); validB = 1'b0; #3;
      chk("to_wait", 32'(readyB), 32'h0);
    end
    tick(); #3;
    chk("to_ready", 32'(readyB), 32'h1);
    chk("to_err", 32'(errB), 32'h1);
    chk("to_rd", rdB, 32'h0);
    tick(); s_readyB = 2'b01; s_rdB[31:0] = 32'h9999_9999; #3;
    chk("to_late_ready", 32'(readyB), 32'h0);
    chk("to_late_svalid", 32'(s_validB), 32'h0);
    tick(); s_readyB = 2'b00;

    // s_ready in the timeout cycle wins over the forced error
    validB = 1'b1; #1;
    for (int k = 1; k <= 3; k++) begin
      tick(); validB = 1'b0;
    end
    tick(); s_readyB = 2'b01; s_rdB[31:0] = 32'h3333_0000; #3;
    chk("tw_ready", 32'(readyB), 32'h1);
    chk("tw_err", 32'(errB), 32'h0);
    chk("tw_rd", rdB, 32'h3333_0000);
    tick(); s_readyB = 2'b00;

    // 6: reset while BUSY abandons the access
    aA = 32'h0000_0010; validA = 1'b1; #1;
    chk("r6_svalid", 32'(s_validA), 32'h1);
    tick(); validA = 1'b0; #2;
    rst = 1'b1; s_readyA = 2'b01; validA = 1'b1; #1;
    chk("r6_ready", 32'(readyA), 32'h0);
    chk("r6_err", 32'(errA), 32'h0);
    chk("r6_svalid_rst", 32'(s_validA), 32'h0);
    tick(); tick();
    rst = 1'b0; validA = 1'b0; s_readyA = 2'b00; #3;
    chk("r6_no_ready", 32'(readyA), 32'h0);
    tick(); aA = 32'h0000_0010; validA = 1'b1; #3;
    chk("r6_t1_svalid", 32'(s_validA), 32'h1);
    tick(); validA = 1'b0; s_readyA = 2'b01; s_rdA[31:0] = 32'h0BAD_CAFE; #3;
    chk("r6_t1_ready", 32'(readyA), 32'h1);
    chk("r6_t1_rd", rdA, 32'h0BAD_CAFE);
    chk("r6_t1_err", 32'(errA), 32'h0);
    tick(); s_readyA = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
